// File: rtl/router_1x3.sv
// router_1x3: single-input, three-output byte-serial packet router.
// A header byte {payload_len[7:2], dest[1:0]} is followed by payload_len
// payload bytes and one parity byte (XOR of header and payload). The packet
// is steered into one of three FIFOs, each drained by its own reader.
// Destination 3 is a drop address. A FIFO that is left unread for TIMEOUT
// cycles is flushed.
//
// Ports:
//   clock               system clock, rising edge
//   resetn              asynchronous reset, active high
//   pkt_valid           high on header/payload bytes, low on the parity byte
//   data_in[7:0]        packet byte from the source
//   read_enb_0/1/2      per-FIFO read request
//   busy                source must hold data_in/pkt_valid while high
//   error               parity mismatch on the last routed packet
//   valid_out_0/1/2     FIFO x not empty
//   data_out_0/1/2      registered read data, one-cycle read latency
module router_1x3 #(
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT    = 30
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       pkt_valid,
  input  logic [7:0] data_in,
  input  logic       read_enb_0,
  input  logic       read_enb_1,
  input  logic       read_enb_2,
  output logic       busy,
  output logic       error,
  output logic       valid_out_0,
  output logic       valid_out_1,
  output logic       valid_out_2,
  output logic [7:0] data_out_0,
  output logic [7:0] data_out_1,
  output logic [7:0] data_out_2
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    DECODE, WAIT_EMPTY, LOAD_FIRST, LOAD_DATA, CHECK_PARITY, DROP
  } state_t;

  state_t          state, nxt;
  logic [7:0]      header, parity, parity_byte, wdata;
  logic [1:0]      dest;
  logic [2:0]      empty, full, flush, wr_en, rd_req;
  logic [3:0]      empty4, full4, flush4;
  logic [2:0][7:0] dout_all;
  logic            dest_empty, dest_full, dest_flush, wr_any;

  assign dest   = header[1:0];
  assign rd_req = {read_enb_2, read_enb_1, read_enb_0};

  // Padded to four entries so the drop address indexes a defined bit.
  assign empty4     = {1'b1, empty};
  assign full4      = {1'b1, full};
  assign flush4     = {1'b0, flush};
  assign dest_empty = empty4[dest];
  assign dest_full  = full4[dest];
  assign dest_flush = flush4[dest];

  // State register
  always_ff @(posedge clock or posedge resetn) begin
    if (resetn) state <= DECODE;
    else        state <= nxt;
  end

  // Next-state logic
  always_comb begin
    nxt = state;
    case (state)
      DECODE: begin
        if (pkt_valid) begin
          if (data_in[1:0] == 2'd3)      nxt = DROP;
          else if (empty4[data_in[1:0]]) nxt = LOAD_FIRST;
          else                           nxt = WAIT_EMPTY;
        end
      end
      WAIT_EMPTY: begin
        if (dest_flush)      nxt = DECODE;
        else if (dest_empty) nxt = LOAD_FIRST;
      end
      LOAD_FIRST:   nxt = dest_flush ? DECODE : LOAD_DATA;
      LOAD_DATA: begin
        if (dest_flush)                  nxt = DECODE;
        else if (!dest_full && !pkt_valid) nxt = CHECK_PARITY;
      end
      CHECK_PARITY: nxt = DECODE;
      DROP:         if (!pkt_valid) nxt = DECODE;
      default:      nxt = DECODE;
    endcase
  end

  // Output logic: handshake and FIFO write strobes
  always_comb begin
    busy   = 1'b0;
    wr_any = 1'b0;
    wdata  = data_in;
    case (state)
      WAIT_EMPTY:   busy = 1'b1;
      LOAD_FIRST: begin
        busy   = 1'b1;
        wr_any = 1'b1;
        wdata  = header;
      end
      LOAD_DATA: begin
        busy   = dest_full;
        wr_any = !dest_full;
      end
      CHECK_PARITY: busy = 1'b1;
      default: ;
    endcase
    wr_en = wr_any ? (3'b001 << dest) : '0;
  end

  // Header latch and parity tracking
  always_ff @(posedge clock or posedge resetn) begin
    if (resetn) begin
      header      <= '0;
      parity      <= '0;
      parity_byte <= '0;
      error       <= 1'b0;
    end else begin
      case (state)
        DECODE:     if (pkt_valid) header <= data_in;
        LOAD_FIRST: begin
          parity <= header;
          error  <= 1'b0;
        end
        LOAD_DATA: begin
          if (!dest_full) begin
            if (pkt_valid) parity      <= parity ^ data_in;
            else           parity_byte <= data_in;
          end
        end
        CHECK_PARITY: error <= (parity_byte != parity);
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_fifo
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [CW-1:0] count;
    logic [TW-1:0] tcnt;
    logic [7:0]    dout;
    logic          do_wr, do_rd;

    assign empty[g]    = (count == '0);
    assign full[g]     = (count == CW'(FIFO_DEPTH));
    assign flush[g]    = !empty[g] && !rd_req[g] && (tcnt == TW'(TIMEOUT - 1));
    assign do_wr       = wr_en[g] && !full[g] && !flush[g];
    assign do_rd       = rd_req[g] && !empty[g];
    assign dout_all[g] = dout;

    always_ff @(posedge clock) begin
      if (do_wr) mem[wptr] <= wdata;
    end

    always_ff @(posedge clock or posedge resetn) begin
      if (resetn) begin
        wptr  <= '0;
        rptr  <= '0;
        count <= '0;
        dout  <= '0;
        tcnt  <= '0;
      end else begin
        if (flush[g]) begin
          wptr  <= '0;
          rptr  <= '0;
          count <= '0;
        end else begin
          if (do_wr) wptr <= (wptr == AW'(FIFO_DEPTH - 1)) ? '0 : wptr + 1'b1;
          if (do_rd) begin
            rptr <= (rptr == AW'(FIFO_DEPTH - 1)) ? '0 : rptr + 1'b1;
            dout <= mem[rptr];
          end
          count <= count + CW'(do_wr) - CW'(do_rd);
        end
        // Counts cycles the FIFO sits unread; wraps to zero on the flush edge.
        if (empty[g] || rd_req[g] || flush[g]) tcnt <= '0;
        else                                   tcnt <= tcnt + 1'b1;
      end
    end
  end

  assign valid_out_0 = !empty[0];
  assign valid_out_1 = !empty[1];
  assign valid_out_2 = !empty[2];
  assign data_out_0  = dout_all[0];
  assign data_out_1  = dout_all[1];
  assign data_out_2  = dout_all[2];

endmodule

// File: tb/tb_router_1x3.sv
// Self-checking bench for router_1x3. Expected bytes are queued per FIFO as
// the source drives them; a monitor queues the bytes the DUT actually reads
// out, and each test task pops and compares the two.
module tb_router_1x3;

  logic       clock = 1'b0;
  logic       resetn, pkt_valid, read_enb_0, read_enb_1, read_enb_2;
  logic [7:0] data_in;
  logic       busy, error, valid_out_0, valid_out_1, valid_out_2;
  logic [7:0] data_out_0, data_out_1, data_out_2;

  router_1x3 #(.FIFO_DEPTH(16), .TIMEOUT(30)) dut (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .read_enb_0(read_enb_0), .read_enb_1(read_enb_1), .read_enb_2(read_enb_2),
    .busy(busy), .error(error),
    .valid_out_0(valid_out_0), .valid_out_1(valid_out_1), .valid_out_2(valid_out_2),
    .data_out_0(data_out_0), .data_out_1(data_out_1), .data_out_2(data_out_2)
  );

  always #5 clock = ~clock;

  int unsigned tests = 0, fails = 0;
  logic [7:0] exp0[$], exp1[$], exp2[$], obs0[$], obs1[$], obs2[$];
  int unsigned busy_cnt = 0, valid0_cnt = 0;
  logic        any_valid = 1'b0;
  logic [2:0]  mon_rd;
  logic [7:0]  e, a;

  always @(negedge clock) begin
    if (busy === 1'b1) busy_cnt++;
    if (valid_out_0 === 1'b1 && read_enb_0 === 1'b0) valid0_cnt++;
    if ((valid_out_0 | valid_out_1 | valid_out_2) === 1'b1) any_valid = 1'b1;
  end

  // A read is performed on the edge where read_enb and valid_out are both high.
  always @(posedge clock) begin
    mon_rd = {read_enb_2 & valid_out_2, read_enb_1 & valid_out_1, read_enb_0 & valid_out_0};
    #1;
    if (mon_rd[0] === 1'b1) obs0.push_back(data_out_0);
    if (mon_rd[1] === 1'b1) obs1.push_back(data_out_1);
    if (mon_rd[2] === 1'b1) obs2.push_back(data_out_2);
  end

  function automatic void push_exp(input int d, input logic [7:0] b);
    case (d)
      0: exp0.push_back(b);
      1: exp1.push_back(b);
      2: exp2.push_back(b);
      default: ;
    endcase
  endfunction

  function automatic int obs_size(input int x);
    case (x)
      0: return obs0.size();
      1: return obs1.size();
      default: return obs2.size();
    endcase
  endfunction

  task automatic drive_byte(input logic [7:0] b, input logic v);
    int unsigned guard = 0;
    data_in   = b;
    pkt_valid = v;
    while (busy === 1'b1 && guard < 300) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 300) begin
      tests++; fails++;
      $display("FAIL busy_stall byte %h still held after %0d cycles, required release", b, guard);
    end
    @(negedge clock);
  endtask

  task automatic send_packet(input int d, input int len, input bit bad);
    logic [7:0] hdr, par, b;
    hdr = {len[5:0], d[1:0]};
    par = hdr;
    push_exp(d, hdr);
    drive_byte(hdr, 1'b1);
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom_range(0, 255));
      par ^= b;
      push_exp(d, b);
      drive_byte(b, 1'b1);
    end
    if (bad) par = par + 8'd1;
    push_exp(d, par);
    drive_byte(par, 1'b0);
    pkt_valid = 1'b0;
    data_in   = '0;
  endtask

  task automatic wait_obs(input int x, input int n);
    int unsigned guard = 0;
    while (obs_size(x) < n && guard < 400) begin
      @(negedge clock);
      guard++;
    end
    if (obs_size(x) < n) begin
      tests++; fails++;
      $display("FAIL drain_timeout fifo %0d got %0d bytes, required %0d", x, obs_size(x), n);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b1; pkt_valid = 1'b0; data_in = '0;
    read_enb_0 = 1'b0; read_enb_1 = 1'b0; read_enb_2 = 1'b0;
    repeat (3) @(negedge clock);
    tests++; if (busy !== 1'b0)        begin fails++; $display("FAIL reset_busy got %b required 0", busy); end
    tests++; if (error !== 1'b0)       begin fails++; $display("FAIL reset_error got %b required 0", error); end
    tests++; if ({valid_out_2, valid_out_1, valid_out_0} !== 3'b000)
      begin fails++; $display("FAIL reset_valid got %b%b%b required 000", valid_out_2, valid_out_1, valid_out_0); end
    tests++; if (data_out_0 !== 8'h00) begin fails++; $display("FAIL reset_dout0 got %h required 00", data_out_0); end
    tests++; if (data_out_1 !== 8'h00) begin fails++; $display("FAIL reset_dout1 got %h required 00", data_out_1); end
    tests++; if (data_out_2 !== 8'h00) begin fails++; $display("FAIL reset_dout2 got %h required 00", data_out_2); end
    resetn = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_basic();
    read_enb_0 = 1'b1;
    busy_cnt = 0;
    send_packet(0, 4, 1'b0);
    repeat (3) @(negedge clock);
    tests++; if (busy_cnt != 2) begin fails++; $display("FAIL basic_busy_cycles got %0d required 2", busy_cnt); end
    tests++; if (error !== 1'b0) begin fails++; $display("FAIL basic_error got %b required 0", error); end
    tests++; if (exp0[0] !== 8'h10) begin fails++; $display("FAIL basic_header got %h required 10", exp0[0]); end
    wait_obs(0, 6);
    while (exp0.size() > 0) begin
      e = exp0.pop_front(); tests++;
      if (obs0.size() == 0) begin fails++; $display("FAIL basic_data got nothing required %h", e); end
      else begin a = obs0.pop_front(); if (a !== e) begin fails++; $display("FAIL basic_data got %h required %h", a, e); end end
    end
    tests++; if (valid_out_0 !== 1'b0) begin fails++; $display("FAIL basic_drained got %b required 0", valid_out_0); end
  endtask

  task automatic test_parity_error();
    read_enb_2 = 1'b1;
    send_packet(2, 4, 1'b1);
    repeat (2) @(negedge clock);
    tests++; if (error !== 1'b1) begin fails++; $display("FAIL parity_error_set got %b required 1", error); end
    repeat (10) @(negedge clock);
    tests++; if (error !== 1'b1) begin fails++; $display("FAIL parity_error_hold got %b required 1", error); end
    wait_obs(2, 6);
    while (exp2.size() > 0) begin
      e = exp2.pop_front(); tests++;
      if (obs2.size() == 0) begin fails++; $display("FAIL parity_data got nothing required %h", e); end
      else begin a = obs2.pop_front(); if (a !== e) begin fails++; $display("FAIL parity_data got %h required %h", a, e); end end
    end
    send_packet(0, 2, 1'b0);
    repeat (2) @(negedge clock);
    tests++; if (error !== 1'b0) begin fails++; $display("FAIL parity_error_clear got %b required 0", error); end
    wait_obs(0, 4);
    while (exp0.size() > 0) begin
      e = exp0.pop_front(); tests++;
      if (obs0.size() == 0) begin fails++; $display("FAIL parity_next_data got nothing required %h", e); end
      else begin a = obs0.pop_front(); if (a !== e) begin fails++; $display("FAIL parity_next_data got %h required %h", a, e); end end
    end
  endtask

  task automatic test_fifo_full();
    read_enb_1 = 1'b0;
    fork
      send_packet(1, 20, 1'b0);
      begin
        repeat (20) @(negedge clock);
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL full_busy got %b required 1", busy); end
        tests++; if (valid_out_1 !== 1'b1) begin fails++; $display("FAIL full_valid got %b required 1", valid_out_1); end
        read_enb_1 = 1'b1;
        @(negedge clock);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL full_busy_release got %b required 0", busy); end
      end
    join
    wait_obs(1, 22);
    while (exp1.size() > 0) begin
      e = exp1.pop_front(); tests++;
      if (obs1.size() == 0) begin fails++; $display("FAIL full_data got nothing required %h", e); end
      else begin a = obs1.pop_front(); if (a !== e) begin fails++; $display("FAIL full_data got %h required %h", a, e); end end
    end
  endtask

  task automatic test_drop();
    busy_cnt = 0;
    any_valid = 1'b0;
    send_packet(3, 8, 1'b0);
    repeat (3) @(negedge clock);
    tests++; if (busy_cnt != 0) begin fails++; $display("FAIL drop_busy got %0d cycles required 0", busy_cnt); end
    tests++; if (any_valid !== 1'b0) begin fails++; $display("FAIL drop_valid got %b required 0", any_valid); end
    send_packet(1, 3, 1'b0);
    wait_obs(1, 5);
    while (exp1.size() > 0) begin
      e = exp1.pop_front(); tests++;
      if (obs1.size() == 0) begin fails++; $display("FAIL drop_next_data got nothing required %h", e); end
      else begin a = obs1.pop_front(); if (a !== e) begin fails++; $display("FAIL drop_next_data got %h required %h", a, e); end end
    end
  endtask

  task automatic test_timeout();
    logic [7:0] held;
    int unsigned guard = 0;
    read_enb_0 = 1'b0;
    held = data_out_0;
    valid0_cnt = 0;
    send_packet(0, 2, 1'b0);
    tests++; if (valid_out_0 !== 1'b1) begin fails++; $display("FAIL timeout_valid_before got %b required 1", valid_out_0); end
    while (valid_out_0 === 1'b1 && guard < 60) begin
      @(negedge clock);
      guard++;
    end
    tests++; if (valid_out_0 !== 1'b0) begin fails++; $display("FAIL timeout_flush got %b required 0", valid_out_0); end
    tests++; if (valid0_cnt != 30) begin fails++; $display("FAIL timeout_cycles got %0d required 30", valid0_cnt); end
    tests++; if (data_out_0 !== held) begin fails++; $display("FAIL timeout_dout got %h required %h", data_out_0, held); end
    tests++; if (obs0.size() != 0) begin fails++; $display("FAIL timeout_reads got %0d required 0", obs0.size()); end
    exp0.delete();
    repeat (3) @(negedge clock);
    tests++; if (valid_out_0 !== 1'b0) begin fails++; $display("FAIL timeout_stays_empty got %b required 0", valid_out_0); end
  endtask

  task automatic test_wait_empty();
    read_enb_2 = 1'b0;
    send_packet(2, 1, 1'b0);
    fork
      send_packet(2, 2, 1'b0);
      begin
        repeat (8) @(negedge clock);
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL wait_empty_busy got %b required 1", busy); end
        tests++; if (valid_out_2 !== 1'b1) begin fails++; $display("FAIL wait_empty_valid got %b required 1", valid_out_2); end
        read_enb_2 = 1'b1;
      end
    join
    wait_obs(2, 7);
    while (exp2.size() > 0) begin
      e = exp2.pop_front(); tests++;
      if (obs2.size() == 0) begin fails++; $display("FAIL wait_empty_data got nothing required %h", e); end
      else begin a = obs2.pop_front(); if (a !== e) begin fails++; $display("FAIL wait_empty_data got %h required %h", a, e); end end
    end
    tests++; if (error !== 1'b0) begin fails++; $display("FAIL wait_empty_error got %b required 0", error); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity_error();
    test_fifo_full();
    test_drop();
    test_timeout();
    test_wait_empty();
    repeat (4) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish, required completion");
    $fatal(1);
  end

endmodule

// File: doc/router_1x3.md
Name: router_1x3

Overview:
- Single-input, three-output packet router. Byte-serial packets on data_in are steered to one of three 16-deep output FIFOs by the 2-bit destination address in the header.
- A downstream reader drains each FIFO independently.
- Sits between a packet source (pkt_valid/busy handshake) and three output consumers (valid_out_x/read_enb_x handshake).

Parameters:
- FIFO_DEPTH, 16, entries per output FIFO.
- TIMEOUT, 30, cycles that valid_out_x may stay unread before FIFO x is soft-flushed.

Ports:
- clock  input  1  single system clock; all state changes on rising edge.
- resetn  input  1  reset; asynchronous and active-high (resetn=1 resets).
- pkt_valid  input  1  high during header and payload bytes; low on the parity byte.
- data_in  input  8  packet byte.
- read_enb_0/1/2  input  1 each  read request for FIFO 0/1/2.
- busy  output  1  source must hold data_in/pkt_valid while high.
- error  output  1  parity mismatch flag for the last packet.
- valid_out_0/1/2  output  1 each  FIFO x not empty.
- data_out_0/1/2  output  8 each  registered read data.

Behaviour:
- Packet format: header = {payload_len[7:2], dest_addr[1:0]}, then payload_len bytes, then 1 parity byte. Parity = XOR of the header and all payload bytes.
- pkt_valid falls on the parity byte. dest 0..2 are valid. dest 3 means the packet is dropped.
- Reset (async): FSM enters DECODE; all FIFOs are emptied; data_out_x = 0; error = 0; busy = 0; valid_out_x = 0; timeout counters clear.
- FSM states:
  - DECODE (busy=0):
    - On pkt_valid=1, latch data_in into the header register.
    - dest 3 -> DROP.
    - FIFO[dest] empty -> LOAD_FIRST.
    - Otherwise -> WAIT_EMPTY.
  - WAIT_EMPTY (busy=1): -> LOAD_FIRST when FIFO[dest] is empty.
  - LOAD_FIRST (busy=1):
    - Write the latched header into FIFO[dest].
    - Internal parity = header; clear error.
    - -> LOAD_DATA.
  - LOAD_DATA (busy = FIFO[dest] full, combinational):
    - Each cycle with FIFO not full, write data_in and XOR it into the internal parity.
    - If pkt_valid=0 that byte is the parity byte. It is written but not XORed, and is compared against the internal parity. -> CHECK_PARITY.
    - While full: no write, no parity update, stay.
  - CHECK_PARITY (busy=1): error is registered (1 on mismatch). -> DECODE.
  - DROP (busy=0): discard bytes; return to DECODE on the first cycle with pkt_valid=0, which consumes the parity byte.
- error holds its value until the next LOAD_FIRST or reset.
- Each FIFO is 16x8 with separate pointers. A write and a read in the same cycle are both performed; count stays unchanged.
  - Write when full: ignored.
  - Read when empty: ignored, data_out_x held.
- Reads: on a rising edge with read_enb_x=1 and FIFO x non-empty, data_out_x <= head entry and the FIFO pops (1-cycle latency). Otherwise data_out_x holds.
- valid_out_x = ~empty_x (combinational).
- Soft reset:
  - A per-FIFO counter increments each cycle valid_out_x=1 and read_enb_x=0.
  - It clears on any read or when the FIFO is empty.
  - On reaching TIMEOUT, FIFO x is flushed to empty; data_out_x is unchanged.
  - If x is the current destination, the FSM returns to DECODE.
  - The flush has priority over a same-cycle write.
- Reset mid-packet: the packet is discarded; the source must restart with a header.

Test Plan:
- Reset, then send dest=0, len=4, correct parity, read_enb_0=1 -> valid_out_0 rises after LOAD_FIRST. data_out_0 sequence: header 0x10, 4 payload bytes, parity. error=0; busy high for 1 cycle at start and 1 cycle at end.
- Packet dest=2, len=4, parity+1 -> error=1 after CHECK_PARITY, and error stays 1 until the next packet's LOAD_FIRST.
- dest=1, len=20, read_enb_1=0 initially -> FIFO 1 fills at 16 entries and busy=1. Assert read_enb_1 -> busy drops, remaining bytes are accepted, all 22 bytes are read out in order.
- dest=3, len=8 -> busy never asserts, no FIFO written, all valid_out stay 0. The next valid packet routes normally.
- Write a packet to FIFO 0, keep read_enb_0=0 for 30 cycles -> FIFO 0 flushed, valid_out_0=0.
- Send a second packet to non-empty FIFO 2 -> busy held in WAIT_EMPTY until FIFO 2 drains, then the header is accepted.
